// File: rtl/acu_result_arbiter.sv
// acu_result_arbiter
// Picks one finished ACU result per cycle from the reservation-station slots
// using round-robin order. The pick is buffered in a small FIFO and presented
// on the common data bus (CDB) with a valid/ready handshake. A one-hot grant
// pulse tells the reservation station which slot was consumed.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous pipeline flush (clears FIFO, keeps ptr)
//   in_valid   in   [SIZE]        slot i holds a finished result
//   in_tag     in   [SIZE*TAG_W]  ROB tag per slot, slot i at [i*TAG_W +: TAG_W]
//   in_data    in   [SIZE*32]     result per slot, slot i at [i*32 +: 32]
//   grant      out  [SIZE]        combinational one-hot/zero accept pulse
//   cdb_valid  out  FIFO head valid
//   cdb_tag    out  FIFO head tag
//   cdb_data   out  FIFO head data
//   cdb_ready  in   consumer accepts head when cdb_valid & cdb_ready
module acu_result_arbiter #(
    parameter int unsigned SIZE  = 15,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [SIZE-1:0]        in_valid,
    input  logic [SIZE*TAG_W-1:0]  in_tag,
    input  logic [SIZE*32-1:0]     in_data,
    output logic [SIZE-1:0]        grant,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [31:0]            cdb_data,
    input  logic                   cdb_ready
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [TAG_W-1:0]  tag_arr  [SIZE];
    logic [DATA_W-1:0] data_arr [SIZE];

    logic              any_valid;
    logic              hi_found;
    logic [PTR_W-1:0]  hi_sel;
    logic [PTR_W-1:0]  lo_sel;
    logic [PTR_W-1:0]  sel;
    logic              can_accept;
    logic              push;
    logic              pop;

    // Unpack flat slot buses into per-slot arrays
    for (genvar g = 0; g < SIZE; g++) begin : g_unpack
        assign tag_arr[g]  = in_tag[g*TAG_W +: TAG_W];
        assign data_arr[g] = in_data[g*DATA_W +: DATA_W];
    end

    // Round-robin pick: lowest valid slot at or above ptr, else lowest valid
    // slot overall (the scan has wrapped past SIZE-1).
    always_comb begin
        any_valid = 1'b0;
        hi_found  = 1'b0;
        hi_sel    = '0;
        lo_sel    = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                any_valid = 1'b1;
                lo_sel    = PTR_W'(i);
                if (PTR_W'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_sel   = PTR_W'(i);
                end
            end
        end
        sel = hi_found ? hi_sel : lo_sel;
    end

    assign cdb_valid  = (cnt_q != '0);
    assign pop        = cdb_valid & cdb_ready;
    // A same-cycle pop frees a slot even when the FIFO is full
    assign can_accept = (cnt_q < CNT_W'(DEPTH)) | pop;
    assign push       = any_valid & can_accept & ~flush & rst;

    always_comb begin
        grant = '0;
        if (push) begin
            grant[sel] = 1'b1;
        end
    end

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Next-state for arbitration pointer and FIFO bookkeeping
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            ptr_d = (sel == PTR_W'(SIZE - 1)) ? '0 : sel + PTR_W'(1);
        end
        if (flush) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end else begin
            if (push) begin
                wr_d = ptr_inc(wr_q);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers and FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                tag_mem_q[j]  <= '0;
                data_mem_q[j] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            if (push) begin
                tag_mem_q[wr_q]  <= tag_arr[sel];
                data_mem_q[wr_q] <= data_arr[sel];
            end
        end
    end

    // Head is read straight from storage: no path from in_* to cdb_*
    assign cdb_tag  = tag_mem_q[rd_q];
    assign cdb_data = data_mem_q[rd_q];

endmodule
